// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with load-use stall detection and
//            EX/MEM, MEM/WB operand forwarding into the ALU inputs.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [3:0]  id_alu_op,
    input  logic        id_src_pc,
    input  logic        id_src_imm,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        id_reg_write,
    input  logic        flush,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_write,
    input  logic [31:0] mem_result,
    input  logic [4:0]  wb_rd,
    input  logic        wb_reg_write,
    input  logic [31:0] wb_result,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_op_ctrl,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [4:0]  ex_rd,
    output logic [31:0] ex_store_data,
    output logic        id_stall
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_rs1_data;
    logic [31:0] r_rs2_data;
    logic [31:0] r_imm;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [3:0]  r_alu_op;
    logic        r_src_pc;
    logic        r_src_imm;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_reg_write;

    logic        w_stall;
    logic        w_bubble;
    logic [31:0] w_fwd_rs1;
    logic [31:0] w_fwd_rs2;

    // A flushed instruction is being discarded anyway, so it must never stall.
    assign w_stall = ~flush & r_valid & r_mem_read & (r_rd != 5'd0) & id_valid &
                     ((r_rd == id_rs1) | (r_rd == id_rs2));
    assign w_bubble = flush | w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || w_bubble) begin
            r_valid     <= 1'b0;
            r_pc        <= 32'd0;
            r_rs1_data  <= 32'd0;
            r_rs2_data  <= 32'd0;
            r_imm       <= 32'd0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_rd        <= 5'd0;
            r_alu_op    <= 4'd0;
            r_src_pc    <= 1'b0;
            r_src_imm   <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_reg_write <= 1'b0;
        end else begin
            r_valid     <= id_valid;
            r_pc        <= id_pc;
            r_rs1_data  <= id_rs1_data;
            r_rs2_data  <= id_rs2_data;
            r_imm       <= id_imm;
            r_rs1       <= id_rs1;
            r_rs2       <= id_rs2;
            r_rd        <= id_rd;
            r_alu_op    <= id_alu_op;
            r_src_pc    <= id_src_pc;
            r_src_imm   <= id_src_imm;
            r_mem_read  <= id_mem_read;
            r_mem_write <= id_mem_write;
            r_reg_write <= id_reg_write;
        end
    end

    // Youngest producer (EX/MEM) wins; x0 is hard-wired zero and never forwarded.
    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == r_rs1))
            w_fwd_rs1 = mem_result;
        else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == r_rs1))
            w_fwd_rs1 = wb_result;
    end

    always_comb begin
        w_fwd_rs2 = r_rs2_data;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == r_rs2))
            w_fwd_rs2 = mem_result;
        else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == r_rs2))
            w_fwd_rs2 = wb_result;
    end

    assign alu_in1       = r_src_pc  ? r_pc  : w_fwd_rs1;
    assign alu_in2       = r_src_imm ? r_imm : w_fwd_rs2;
    assign ex_store_data = w_fwd_rs2;
    assign alu_op_ctrl   = r_alu_op;
    assign ex_valid      = r_valid;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_rd         = r_rd;
    assign id_stall      = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Directed self-checking bench for id_ex_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_op;
    logic        id_src_pc, id_src_imm, id_mem_read, id_mem_write, id_reg_write;
    logic        flush;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [3:0]  alu_op_ctrl;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, id_stall;
    logic [4:0]  ex_rd;

    int n_cmp  = 0;
    int n_fail = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_src_pc(id_src_pc), .id_src_imm(id_src_imm), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .flush(flush),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op_ctrl(alu_op_ctrl),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
        .id_stall(id_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_op = 0;
        id_src_pc = 0; id_src_imm = 0; id_mem_read = 0; id_mem_write = 0; id_reg_write = 0;
        flush = 0; mem_rd = 0; mem_reg_write = 0; mem_result = 0;
        wb_rd = 0; wb_reg_write = 0; wb_result = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        id_valid = 1; id_rs1_data = 32'h1234; id_reg_write = 1; id_rd = 5'd9;
        rst = 1;
        tick();
        tick();
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_rd !== 5'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got valid=%b rw=%b rd=%0d, want 0/0/0", ex_valid, ex_reg_write, ex_rd);
        end
        n_cmp++;
        if (alu_in1 !== 32'd0 || alu_in2 !== 32'd0 || ex_store_data !== 32'd0 || alu_op_ctrl !== 4'd0) begin
            n_fail++; $display("FAIL reset_data: got in1=%h in2=%h sd=%h op=%h, want all 0", alu_in1, alu_in2, ex_store_data, alu_op_ctrl);
        end
        n_cmp++;
        if (id_stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b want 0", id_stall);
        end
        clear_inputs();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_plain();
        clear_inputs();
        id_valid = 1; id_pc = 32'h100; id_rs1 = 1; id_rs2 = 2; id_rd = 5;
        id_rs1_data = 5; id_rs2_data = 7; id_reg_write = 1;
        tick();
        n_cmp++;
        if (alu_in1 !== 32'd5 || alu_in2 !== 32'd7 || ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL plain_pass: got in1=%h in2=%h v=%b, want 5/7/1", alu_in1, alu_in2, ex_valid);
        end
        n_cmp++;
        if (ex_rd !== 5'd5 || ex_reg_write !== 1'b1 || ex_store_data !== 32'd7) begin
            n_fail++; $display("FAIL plain_ctrl: got rd=%0d rw=%b sd=%h, want 5/1/7", ex_rd, ex_reg_write, ex_store_data);
        end
        // PC as operand 1, store with alu_op passthrough
        id_src_pc = 1; id_alu_op = 4'hA; id_mem_write = 1; id_reg_write = 0; id_pc = 32'h2000;
        tick();
        n_cmp++;
        if (alu_in1 !== 32'h2000 || alu_op_ctrl !== 4'hA || ex_mem_write !== 1'b1 || ex_reg_write !== 1'b0) begin
            n_fail++; $display("FAIL plain_srcpc: got in1=%h op=%h mw=%b rw=%b, want 2000/a/1/0", alu_in1, alu_op_ctrl, ex_mem_write, ex_reg_write);
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        id_valid = 1; id_rd = 3; id_mem_read = 1; id_reg_write = 1; id_rs1 = 1; id_rs2 = 2;
        tick();
        clear_inputs();
        id_valid = 1; id_rs1 = 3; id_rs2 = 0; id_rd = 6; id_rs1_data = 32'h33; id_reg_write = 1;
        #1;
        n_cmp++;
        if (id_stall !== 1'b1) begin
            n_fail++; $display("FAIL loaduse_stall: got %b want 1", id_stall);
        end
        tick();
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0 || ex_rd !== 5'd0) begin
            n_fail++; $display("FAIL loaduse_bubble: got v=%b mr=%b rw=%b mw=%b rd=%0d, want all 0", ex_valid, ex_mem_read, ex_reg_write, ex_mem_write, ex_rd);
        end
        n_cmp++;
        if (id_stall !== 1'b0) begin
            n_fail++; $display("FAIL loaduse_release: got %b want 0", id_stall);
        end
        tick();
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || alu_in1 !== 32'h33) begin
            n_fail++; $display("FAIL loaduse_enter: got v=%b rd=%0d in1=%h, want 1/6/33", ex_valid, ex_rd, alu_in1);
        end
    endtask

    task automatic test_forward();
        clear_inputs();
        id_valid = 1; id_rs1 = 4; id_rs2 = 5; id_rs1_data = 32'h1; id_rs2_data = 32'h2;
        tick();
        clear_inputs();
        mem_rd = 4; mem_reg_write = 1; mem_result = 32'h11;
        wb_rd = 4; wb_reg_write = 1; wb_result = 32'h22;
        #1;
        n_cmp++;
        if (alu_in1 !== 32'h11) begin
            n_fail++; $display("FAIL fwd_mem_priority: got %h want 11", alu_in1);
        end
        mem_reg_write = 0;
        #1;
        n_cmp++;
        if (alu_in1 !== 32'h22) begin
            n_fail++; $display("FAIL fwd_wb: got %h want 22", alu_in1);
        end
        wb_reg_write = 0;
        #1;
        n_cmp++;
        if (alu_in1 !== 32'h1) begin
            n_fail++; $display("FAIL fwd_none: got %h want 1", alu_in1);
        end
        mem_rd = 5; mem_reg_write = 1; mem_result = 32'h55;
        #1;
        n_cmp++;
        if (alu_in2 !== 32'h55 || ex_store_data !== 32'h55 || alu_in1 !== 32'h1) begin
            n_fail++; $display("FAIL fwd_rs2_mem: got in2=%h sd=%h in1=%h, want 55/55/1", alu_in2, ex_store_data, alu_in1);
        end
    endtask

    task automatic test_x0();
        clear_inputs();
        id_valid = 1; id_rs1 = 0; id_rs2 = 0; id_rs1_data = 0; id_rs2_data = 0;
        tick();
        clear_inputs();
        mem_rd = 0; mem_reg_write = 1; mem_result = 32'hFF;
        wb_rd = 0; wb_reg_write = 1; wb_result = 32'hEE;
        #1;
        n_cmp++;
        if (alu_in2 !== 32'd0 || ex_store_data !== 32'd0 || alu_in1 !== 32'd0) begin
            n_fail++; $display("FAIL x0_no_forward: got in1=%h in2=%h sd=%h, want 0/0/0", alu_in1, alu_in2, ex_store_data);
        end
    endtask

    task automatic test_flush_imm();
        clear_inputs();
        id_valid = 1; id_rd = 3; id_mem_read = 1; id_reg_write = 1;
        tick();
        clear_inputs();
        id_valid = 1; id_rs1 = 3; id_rd = 8; id_reg_write = 1; flush = 1;
        #1;
        n_cmp++;
        if (id_stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_stall: got %b want 0", id_stall);
        end
        tick();
        n_cmp++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_rd !== 5'd0) begin
            n_fail++; $display("FAIL flush_bubble: got v=%b rw=%b rd=%0d, want 0/0/0", ex_valid, ex_reg_write, ex_rd);
        end
        clear_inputs();
        id_valid = 1; id_rs2 = 7; id_rs2_data = 32'h70; id_src_imm = 1; id_imm = 32'hFFFFFFFC;
        tick();
        mem_rd = 7; mem_reg_write = 1; mem_result = 32'hABCD;
        #1;
        n_cmp++;
        if (alu_in2 !== 32'hFFFFFFFC || ex_store_data !== 32'hABCD) begin
            n_fail++; $display("FAIL imm_select: got in2=%h sd=%h, want fffffffc/abcd", alu_in2, ex_store_data);
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        id_valid = 1; id_rs1 = 1; id_rs1_data = 32'h99; id_rd = 2; id_reg_write = 1;
        tick();
        n_cmp++;
        if (ex_valid !== 1'b1 || alu_in1 !== 32'h99) begin
            n_fail++; $display("FAIL areset_pre: got v=%b in1=%h, want 1/99", ex_valid, alu_in1);
        end
        #1 rst = 1;
        #1;
        n_cmp++;
        if (ex_valid !== 1'b0 || alu_in1 !== 32'd0 || ex_rd !== 5'd0 || ex_reg_write !== 1'b0) begin
            n_fail++; $display("FAIL areset_clear: got v=%b in1=%h rd=%0d rw=%b, want 0/0/0/0", ex_valid, alu_in1, ex_rd, ex_reg_write);
        end
        #1 rst = 0;
        tick();
        n_cmp++;
        if (ex_valid !== 1'b1 || alu_in1 !== 32'h99 || ex_rd !== 5'd2) begin
            n_fail++; $display("FAIL areset_reload: got v=%b in1=%h rd=%0d, want 1/99/2", ex_valid, alu_in1, ex_rd);
        end
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_plain();
        test_load_use();
        test_forward();
        test_x0();
        test_flush_imm();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
